led_pio_sequencer: RTL and testbench
====================================

# led_pio_sequencer

Avalon-MM write master that owns the 8-bit LED PIO and is its only writer. A prescaled tick advances a selectable LED pattern: off/hold, blink, chase or bounce. A valid/ready event port lets other logic write, set or clear LED bits. The block arbitrates pattern updates and events onto the PIO's single write port and keeps a shadow copy of the PIO output register.

## Interface
Parameters:
- `LED_W`, 8: LED/PIO data width; writedata upper bits are zero.
- `TICK_DIV`, 5000000: clocks per pattern step (0.1 s at 50 MHz); ≥2.
- `CNT_W`, 24: prescaler counter width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  async active-high reset
- `enable`  in  1  run prescaler and pattern engine
- `mode`  in  2  0 hold, 1 blink, 2 chase, 3 bounce
- `evt_valid`  in  1  event request
- `evt_ready`  out  1  event accepted when valid&&ready
- `evt_op`  in  2  0 write, 1 set bits, 2 clear bits, 3 reserved
- `evt_data`  in  LED_W  event bit mask/value
- `pio_address`  out  3  PIO register: 0 data, 4 outset, 5 outclear
- `pio_chipselect`  out  1  PIO select
- `pio_write_n`  out  1  PIO write strobe, active low
- `pio_writedata`  out  32  {zeros, LED_W data}
- `shadow`  out  LED_W  mirror of PIO data register
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM has two states: IDLE and WRITE. WRITE lasts exactly one cycle, with chipselect=1, write_n=0 and address/writedata valid. The PIO has no waitrequest, so the write completes in that cycle. The FSM then returns to IDLE.
- In IDLE, `evt_ready`=1. In WRITE, `evt_ready`=0.
- Arbitration in IDLE:
  - An accepted event (valid&&ready) goes to WRITE next cycle with the event's address/data.
  - Otherwise, if `pat_pend`=1, the FSM goes to WRITE with address 0 and the pattern register, and clears `pat_pend`.
  - Events always win over pattern writes.
- Event op mapping:
  - op0 → address 0, data = evt_data.
  - op1 → address 4.
  - op2 → address 5.
  - op3 → accepted and dropped: no write, FSM stays IDLE, shadow unchanged.
- Shadow register, updated at the end of the WRITE cycle:
  - addr0 → shadow = data.
  - addr4 → shadow |= data.
  - addr5 → shadow &= ~data.
- Prescaler:
  - When `enable`=1, counts 0..TICK_DIV-1 and wraps to 0. The tick is the cycle the count equals TICK_DIV-1.
  - When `enable`=0, the count is held at 0, no ticks occur, and `pat_pend` is cleared.
  - Events are still served while `enable`=0.
- Pattern engine:
  - On a tick with mode≠0, the pattern advances one step and `pat_pend`=1.
  - On a tick with mode=0, nothing happens.
  - Blink: pattern = ~pattern. Seed is all ones.
  - Chase: rotate left by 1 (MSB wraps to bit 0). Seed is 0x01.
  - Bounce: one-hot shift in the current direction, reversing at the ends: 0x01→0x02…0x80→0x40…0x01→0x02. Seed is 0x01, direction up.
- Mode change: any cycle where `mode` differs from its registered copy reloads the seed and direction and sets `pat_pend`=1 if mode≠0. The prescaler is not reset.
- Coalescing: a tick while `pat_pend`=1 still advances the pattern. Only the latest pattern is written; skipped steps are lost by design.
- Pattern writes overwrite bits set by events. Callers use mode 0 for exclusive event control.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `evt_ready`=1, `pio_chipselect`=0, `pio_write_n`=1, `pio_address`=0, `pio_writedata`=0.
  - `shadow`=0, pattern=0, `pat_pend`=0, prescaler=0, registered mode=0.
  - Reset mid-WRITE aborts the strobe immediately, because the PIO outputs are asynchronous-reset registers.
- Event latency: accept in cycle N, PIO strobe in cycle N+1, shadow updated visible in N+2. Maximum event rate is one per 2 cycles.
- Pattern latency: tick in cycle N sets `pat_pend`. The PIO strobe occurs at N+2 if IDLE and no event is accepted at N+1. Otherwise it is delayed one write slot per competing event.
- All PIO outputs are registered. Outside WRITE: chipselect=0, write_n=1, address/writedata hold their last values.
- A tick in the same cycle as a pattern-write launch re-sets `pat_pend` (set has priority over clear).

## Structure
- Package `led_seq_pkg`:
  - mode encodings MODE_HOLD/BLINK/CHASE/BOUNCE.
  - op encodings OP_WRITE/SET/CLR.
  - PIO address constants PIO_DATA=0, PIO_OUTSET=4, PIO_OUTCLR=5.
  - FSM state enum.
- Sub-module `led_tick_gen`: parameterised prescaler with enable in and tick out.
- Top level holds the pattern engine, arbiter/FSM and shadow register.

## Test plan
Sim parameters: TICK_DIV=4, LED_W=8.
- Reset release with mode=0, enable=0, no events, for 50 cycles → no write strobes; all outputs at reset values; shadow=0x00.
- Events write 0x3C, then set 0x81, then clear 0x0C, each issued on `evt_ready` → three strobes at addresses 0/4/5 with data 0x3C/0x81/0x0C; final shadow=0xB1; each strobe 1 cycle after acceptance.
- mode=2, enable=1, for 40 cycles → first write 0x01 (mode change), then one write every 4 cycles: 0x02, 0x04…0x80, 0x01.
- mode=3 → written sequence 0x01, 0x02…0x80, 0x40…0x01, 0x02; mode=1 → alternating 0xFF/0x00.
- evt_valid held high with op1 continuously in mode 2 → events strobe every 2 cycles; pattern write is deferred until evt_valid drops, then writes the latest pattern once (coalesced).
- Assert reset during a WRITE cycle → chipselect=0 and write_n=1 in the same cycle; after release, shadow=0, no pending write, first tick write occurs only after TICK_DIV cycles.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED PIO sequencer.
// Modes, event ops, PIO register offsets and FSM states.
package led_seq_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_CLR   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [2:0] PIO_DATA   = 3'd0;
  localparam logic [2:0] PIO_OUTSET = 3'd4;
  localparam logic [2:0] PIO_OUTCLR = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/led_pio_sequencer_tick.sv
// Pattern-step prescaler: counts 0..TICK_DIV-1 while enabled.
// Held at zero when disabled, so no tick can fire.
module led_tick_gen #(
  parameter int TICK_DIV = 5000000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST);

  // Next count: wrap at LAST, clear when disabled.
  always_comb begin
    cnt_d = '0;
    if (enable_i && (cnt_q != LAST))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// LED PIO write master: pattern engine, event arbiter, shadow.
// Events always beat pattern writes for the single PIO port.
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 5000000,
  parameter int CNT_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             evt_valid,
  output logic             evt_ready,
  input  logic [1:0]       evt_op,
  input  logic [LED_W-1:0] evt_data,
  output logic [2:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  output logic [LED_W-1:0] shadow,
  output logic             busy
);

  localparam logic [LED_W-1:0] ONE =
    {{(LED_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [LED_W-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic             pend_q, pend_d;
  logic             cs_q, cs_d;
  logic             wn_q, wn_d;
  logic [2:0]       addr_q, addr_d;
  logic [LED_W-1:0] data_q, data_d;
  logic [LED_W-1:0] shadow_q, shadow_d;

  logic tick;
  logic mode_chg;
  logic pat_set;
  logic idle;
  logic evt_go;
  logic pat_go;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .enable_i (enable),
    .tick_o   (tick)
  );

  assign mode_chg = (mode != mode_q);
  assign idle     = (state_q == ST_IDLE);
  assign evt_go   = evt_valid && idle
                 && (evt_op != OP_RSVD);
  assign pat_go   = idle && !evt_go && pend_q;

  assign evt_ready      = idle;
  assign busy           = (state_q == ST_WRITE);
  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = {{(32-LED_W){1'b0}}, data_q};
  assign shadow         = shadow_q;

  // Pattern engine: seed on mode change, else step on tick.
  always_comb begin
    pat_d   = pat_q;
    dir_d   = dir_q;
    pat_set = 1'b0;
    if (mode_chg) begin
      dir_d   = 1'b1;
      pat_set = (mode != MODE_HOLD);
      unique case (mode)
        MODE_BLINK:  pat_d = '1;
        MODE_CHASE:  pat_d = ONE;
        MODE_BOUNCE: pat_d = ONE;
        MODE_HOLD:   pat_d = pat_q;
      endcase
    end else if (tick) begin
      pat_set = (mode_q != MODE_HOLD);
      unique case (mode_q)
        MODE_BLINK: pat_d = ~pat_q;
        MODE_CHASE:
          pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        MODE_BOUNCE: begin
          if (dir_q) begin
            if (pat_q[LED_W-1]) begin
              pat_d = pat_q >> 1;
              dir_d = 1'b0;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = 1'b1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        MODE_HOLD: pat_d = pat_q;
      endcase
    end
  end

  // Pending flag: new pattern beats launch clear.
  always_comb begin
    pend_d = pend_q;
    if (!enable)      pend_d = 1'b0;
    else if (pat_set) pend_d = 1'b1;
    else if (pat_go)  pend_d = 1'b0;
  end

  // Arbiter FSM and shadow update on write completion.
  always_comb begin
    state_d  = ST_IDLE;
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    addr_d   = addr_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          evt_go: begin
            state_d = ST_WRITE;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            data_d  = evt_data;
            case (evt_op)
              OP_WRITE: addr_d = PIO_DATA;
              OP_SET:   addr_d = PIO_OUTSET;
              default:  addr_d = PIO_OUTCLR;
            endcase
          end
          pat_go: begin
            state_d = ST_WRITE;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = PIO_DATA;
            data_d  = pat_q;
          end
          default: ;
        endcase
      end
      ST_WRITE: begin
        case (addr_q)
          PIO_DATA:   shadow_d = data_q;
          PIO_OUTSET: shadow_d = shadow_q | data_q;
          PIO_OUTCLR: shadow_d = shadow_q & ~data_q;
          default:    shadow_d = shadow_q;
        endcase
      end
    endcase
  end

  // State, pattern and registered PIO outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_HOLD;
      pat_q    <= '0;
      dir_q    <= 1'b1;
      pend_q   <= 1'b0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode;
      pat_q    <= pat_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed bench for led_pio_sequencer at TICK_DIV=4.
// PIO strobes are logged with cycle stamps and checked in order.
module tb_led_pio_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_op;
  logic [7:0]  evt_data;
  logic [2:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [7:0]  shadow;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_d[$];
  int          q_c[$];

  led_pio_sequencer #(
    .LED_W    (8),
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_op         (evt_op),
    .evt_data       (evt_data),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .shadow         (shadow),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      q_a.push_back({29'd0, pio_address});
      q_d.push_back(pio_writedata);
      q_c.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    q_a.delete();
    q_d.delete();
    q_c.delete();
  endtask

  task automatic pop_wr(output logic [31:0] a,
                        output logic [31:0] d,
                        output int c);
    int n = 0;
    while (q_a.size() == 0 && n < 40) begin
      step();
      n++;
    end
    chk("wr_avail", 32'(q_a.size() > 0), 32'd1);
    if (q_a.size() > 0) begin
      a = q_a.pop_front();
      d = q_d.pop_front();
      c = q_c.pop_front();
    end else begin
      a = '1;
      d = '1;
      c = 0;
    end
  endtask

  task automatic chk_idle_outs(input string tag,
                               input logic [7:0] esh);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(evt_ready), 32'd1);
    chk({tag, "_cs"}, 32'(pio_chipselect), 32'd0);
    chk({tag, "_wn"}, 32'(pio_write_n), 32'd1);
    chk({tag, "_addr"}, 32'(pio_address), 32'd0);
    chk({tag, "_wd"}, pio_writedata, 32'd0);
    chk({tag, "_sh"}, 32'(shadow), 32'(esh));
  endtask

  task automatic send_evt(input logic [1:0] op,
                          input logic [7:0] dat,
                          input logic [2:0] ea,
                          input logic [7:0] esh,
                          input bit strobe);
    chk("evt_rdy", 32'(evt_ready), 32'd1);
    evt_valid = 1'b1;
    evt_op    = op;
    evt_data  = dat;
    step();
    evt_valid = 1'b0;
    chk("evt_cs", 32'(pio_chipselect), 32'(strobe));
    if (strobe) begin
      chk("evt_wn", 32'(pio_write_n), 32'd0);
      chk("evt_addr", 32'(pio_address), 32'(ea));
      chk("evt_wd", pio_writedata, 32'(dat));
      chk("evt_busy", 32'(busy), 32'd1);
      chk("evt_rdy_lo", 32'(evt_ready), 32'd0);
    end
    step();
    chk("evt_shadow", 32'(shadow), 32'(esh));
    chk("evt_cs_off", 32'(pio_chipselect), 32'd0);
  endtask

  task automatic run_seq(input logic [1:0] m,
                         input logic [7:0] exp [16],
                         input int n);
    logic [31:0] a, d;
    int c, pc;
    pc = 0;
    enable = 1'b0;
    repeat (3) step();
    flush();
    mode   = m;
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      pop_wr(a, d, c);
      chk($sformatf("m%0d_addr%0d", m, i), a, 32'd0);
      chk($sformatf("m%0d_data%0d", m, i), d,
          32'(exp[i]));
      if (i == 1)
        chk($sformatf("m%0d_gap%0d", m, i), 32'(c - pc), 32'd3);
      else if (i > 1)
        chk($sformatf("m%0d_gap%0d", m, i), 32'(c - pc), 32'd4);
      pc = c;
    end
  endtask

  initial begin : main
    logic [31:0] a, d;
    int c, pc, n;
    logic [7:0] e_chase  [16];
    logic [7:0] e_bounce [16];
    logic [7:0] e_blink  [16];

    e_chase  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                 8'h40, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00};
    e_bounce = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                 8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                 8'h04, 8'h02, 8'h01, 8'h02};
    e_blink  = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00};

    reset     = 1'b1;
    enable    = 1'b0;
    mode      = 2'd0;
    evt_valid = 1'b0;
    evt_op    = 2'd0;
    evt_data  = 8'h00;

    repeat (3) step();
    chk_idle_outs("rst", 8'h00);
    reset = 1'b0;
    repeat (50) step();
    chk("idle_no_wr", 32'(q_a.size()), 32'd0);
    chk_idle_outs("idle", 8'h00);

    send_evt(2'd0, 8'h3C, 3'd0, 8'h3C, 1'b1);
    send_evt(2'd1, 8'h81, 3'd4, 8'hBD, 1'b1);
    send_evt(2'd2, 8'h0C, 3'd5, 8'hB1, 1'b1);
    send_evt(2'd3, 8'hFF, 3'd0, 8'hB1, 1'b0);
    chk("evt_wr_cnt", 32'(q_a.size()), 32'd3);

    run_seq(2'd2, e_chase, 9);
    run_seq(2'd3, e_bounce, 16);
    run_seq(2'd1, e_blink, 4);

    enable = 1'b0;
    repeat (3) step();
    flush();
    mode   = 2'd2;
    enable = 1'b1;
    step();
    step();
    chk("fl_cs", 32'(pio_chipselect), 32'd1);
    chk("fl_wd", pio_writedata, 32'h01);
    evt_valid = 1'b1;
    evt_op    = 2'd1;
    evt_data  = 8'h10;
    repeat (18) step();
    evt_valid = 1'b0;
    pop_wr(a, d, pc);
    chk("fl_seed", d, 32'h01);
    for (int j = 0; j < 9; j++) begin
      pop_wr(a, d, c);
      chk($sformatf("fl_ev_addr%0d", j), a, 32'd4);
      chk($sformatf("fl_ev_data%0d", j), d, 32'h10);
      chk($sformatf("fl_ev_gap%0d", j), 32'(c - pc), 32'd2);
      pc = c;
    end
    pop_wr(a, d, c);
    chk("fl_pat_addr", a, 32'd0);
    chk("fl_pat_data", d, 32'h20);
    chk("fl_pat_gap", 32'(c - pc), 32'd2);
    pc = c;
    pop_wr(a, d, c);
    chk("fl_next_data", d, 32'h40);
    chk("fl_next_gap", 32'(c - pc), 32'd3);

    n = 0;
    while (pio_chipselect !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("rw_found_wr", 32'(pio_chipselect), 32'd1);
    #1;
    reset     = 1'b1;
    mode      = 2'd0;
    enable    = 1'b0;
    evt_valid = 1'b0;
    #1;
    chk_idle_outs("rw", 8'h00);
    step();
    reset = 1'b0;
    flush();
    repeat (10) step();
    chk("rw_no_pend", 32'(q_a.size()), 32'd0);
    chk("rw_shadow", 32'(shadow), 32'd0);
    mode   = 2'd2;
    enable = 1'b1;
    pop_wr(a, d, pc);
    chk("rw_first", d, 32'h01);
    pop_wr(a, d, c);
    chk("rw_tick_data", d, 32'h02);
    chk("rw_tick_gap", 32'(c - pc), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
